// File: rtl/pipeline_ir_hazard_unit_if.sv
// Pipeline IR / hazard bus: fetch-side inputs and the four IR taps plus
// stall and multiply/divide occupancy status.
interface pipeline_ir_hazard_unit_if #(
  parameter int IR_W = 16
);
  logic [IR_W-1:0] fetch_ir;
  logic            branch_taken;
  logic [IR_W-1:0] IFIDIR;
  logic [IR_W-1:0] IDEXIR;
  logic [IR_W-1:0] EXMEMIR;
  logic [IR_W-1:0] MEMWBIR;
  logic            stall;
  logic            md_busy;

  modport master (
    output fetch_ir, branch_taken,
    input  IFIDIR, IDEXIR, EXMEMIR, MEMWBIR, stall, md_busy
  );

  modport slave (
    input  fetch_ir, branch_taken,
    output IFIDIR, IDEXIR, EXMEMIR, MEMWBIR, stall, md_busy
  );
endinterface

// File: rtl/pipeline_ir_hazard_unit.sv
// Pipeline instruction registers with load-use and multiply/divide
// stall insertion and branch flush.
//
// state  | meaning
// IDLE   | no multi-cycle op in EX beyond its first cycle
// MDBUSY | mult/div held in ID/EX; cnt = further stall cycles remaining
module pipeline_ir_hazard_unit #(
  parameter int          IR_W     = 16,
  parameter logic [15:0] NOP_IR   = 16'h2000,
  parameter int          MULT_CYC = 3,
  parameter int          DIV_CYC  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  pipeline_ir_hazard_unit_if.slave    bus
);

  typedef enum logic {IDLE, MDBUSY} state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h8;
  localparam logic [3:0] OP_STORE = 4'hB;
  localparam logic [3:0] FN_MULT  = 4'h4;
  localparam logic [3:0] FN_DIV   = 4'h5;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            md_busy_q, md_busy_d;
  logic [IR_W-1:0] ifid_q, ifid_d;
  logic [IR_W-1:0] idex_q, idex_d;
  logic [IR_W-1:0] exmem_q, exmem_d;
  logic [IR_W-1:0] memwb_q, memwb_d;

  logic       idex_is_md;
  logic [3:0] idex_cyc;
  logic       ifid_reads_op1;
  logic       ifid_reads_op2;
  logic       lu;
  logic       md_stall;

  // Hazard detection and next-state selection for IRs and the mult/div FSM
  always_comb begin
    idex_is_md     = (idex_q[15:12] == OP_RTYPE) &&
                     ((idex_q[3:0] == FN_MULT) || (idex_q[3:0] == FN_DIV));
    idex_cyc       = (idex_q[3:0] == FN_MULT) ? 4'(MULT_CYC) : 4'(DIV_CYC);
    ifid_reads_op1 = (ifid_q[15:12] == OP_RTYPE) || (ifid_q[15:12] == OP_STORE);
    ifid_reads_op2 = (ifid_q[15:12] == OP_RTYPE) || (ifid_q[15:12] == OP_LOAD) ||
                     (ifid_q[15:12] == OP_STORE);
    lu             = (idex_q[15:12] == OP_LOAD) && (idex_q[11:8] != 4'd0) &&
                     ((ifid_reads_op1 && (ifid_q[11:8] == idex_q[11:8])) ||
                      (ifid_reads_op2 && (ifid_q[7:4]  == idex_q[11:8])));

    md_stall = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (idex_is_md && (idex_cyc > 4'd1)) begin
          md_stall = 1'b1;
          cnt_d    = idex_cyc - 4'd2;
          state_d  = MDBUSY;
        end
      end
      MDBUSY: begin
        if (cnt_q != 4'd0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    md_busy_d = (state_d == MDBUSY);

    // MEM/WB is never held
    memwb_d = exmem_q;
    if (md_stall) begin
      ifid_d  = ifid_q;
      idex_d  = idex_q;
      exmem_d = NOP_IR;
    end else if (bus.branch_taken) begin
      ifid_d  = NOP_IR;
      idex_d  = NOP_IR;
      exmem_d = idex_q;
    end else if (lu) begin
      ifid_d  = ifid_q;
      idex_d  = NOP_IR;
      exmem_d = idex_q;
    end else begin
      ifid_d  = bus.fetch_ir;
      idex_d  = ifid_q;
      exmem_d = idex_q;
    end
  end

  // State registers; reset loads bubbles everywhere and aborts any stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      md_busy_q <= 1'b0;
      ifid_q    <= NOP_IR;
      idex_q    <= NOP_IR;
      exmem_q   <= NOP_IR;
      memwb_q   <= NOP_IR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      md_busy_q <= md_busy_d;
      ifid_q    <= ifid_d;
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      memwb_q   <= memwb_d;
    end
  end

  // A taken branch overrides a load-use hold, so it also clears stall
  assign bus.stall   = md_stall | (lu & ~bus.branch_taken);
  assign bus.md_busy = md_busy_q;
  assign bus.IFIDIR  = ifid_q;
  assign bus.IDEXIR  = idex_q;
  assign bus.EXMEMIR = exmem_q;
  assign bus.MEMWBIR = memwb_q;

endmodule
